// File: rtl/gnr_ctrl_pkg.sv
// Shared types and constants for the GNR attractor controller.
package gnr_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StPeriod,
    StDone
  } state_e;

  localparam int unsigned DefCntW     = 16;
  localparam int unsigned DefMaxSteps = 32'h0000_FFFF;

endpackage

// File: rtl/gnr_vec_cmp.sv
// Combinational equality check of the slow and fast network state vectors.
module gnr_vec_cmp #(
  parameter int unsigned N_NODES = 16
) (
  input  logic [N_NODES-1:0] a,
  input  logic [N_NODES-1:0] b,
  output logic               eq
);

  assign eq = (a == b);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Loads a GNR network, finds an attractor by Floyd cycle detection and measures its period.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned N_NODES   = 16,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned MAX_STEPS = DefMaxSteps
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [N_NODES-1:0] cfg_init,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_meet_steps,
  output logic [CNT_W-1:0]   res_period,
  output logic [N_NODES-1:0] res_state,
  output logic               res_timeout
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

  state_e           state_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] p_q;

  logic vec_eq;
  logic meet;
  logic hit;
  logic run_limit;
  logic per_limit;

  gnr_vec_cmp #(
    .N_NODES(N_NODES)
  ) u_vec_cmp (
    .a (s0_vec),
    .b (s1_vec),
    .eq(vec_eq)
  );

  // s0 only matches step k/2 on even k, so odd-k compares are meaningless.
  assign meet      = (k_q != '0) && !k_q[0] && vec_eq;
  assign hit       = (p_q != '0) && vec_eq;
  assign run_limit = (k_q == MaxCnt);
  assign per_limit = (p_q == MaxCnt);
  assign cfg_ready = (state_q == StIdle);

  // Strobes are combinational so the network holds still on the meet/hit cycle itself.
  always_comb begin
    start_s0 = 1'b0;
    start_s1 = 1'b0;
    case (state_q)
      StRun: begin
        start_s0 = !meet && !run_limit;
        start_s1 = !meet && !run_limit;
      end
      StPeriod: begin
        start_s1 = !hit && !per_limit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      k_q            <= '0;
      p_q            <= '0;
      reset_nos      <= 1'b0;
      init_state     <= '0;
      res_valid      <= 1'b0;
      res_meet_steps <= '0;
      res_period     <= '0;
      res_state      <= '0;
      res_timeout    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            init_state <= cfg_init;
            reset_nos  <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          reset_nos      <= 1'b0;
          k_q            <= '0;
          p_q            <= '0;
          res_meet_steps <= '0;
          res_period     <= '0;
          res_state      <= '0;
          res_timeout    <= 1'b0;
          state_q        <= StRun;
        end
        StRun: begin
          if (meet) begin
            res_state      <= s0_vec;
            res_meet_steps <= k_q;
            state_q        <= StPeriod;
          end else if (run_limit) begin
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state_q     <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StPeriod: begin
          if (hit) begin
            res_period <= p_q;
            res_valid  <= 1'b1;
            state_q    <= StDone;
          end else if (per_limit) begin
            res_timeout <= 1'b1;
            res_period  <= '0;
            res_valid   <= 1'b1;
            state_q     <= StDone;
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/gnr_attractor_ctrl.md
Name: gnr_attractor_ctrl

Overview:
- Drives and observes a GNR Boolean network built from per-node dual-copy instances. Each node has a slow copy s0, which advances once every second start_s0 pulse, and a fast copy s1, which advances on every start_s1 pulse.
- The block loads an initial state and runs Floyd-style cycle detection until s0 == s1. It then freezes s0 and steps s1 alone to measure the attractor period.
- Results are reported through a valid/ready handshake.
- It sits between the host/stream interface and the network array, and is the sole source of the nodes' reset_nos, start_s0, start_s1 and init_state.

Parameters:
- N_NODES, 16, number of network nodes (width of state vectors).
- CNT_W, 16, width of the step and period counters.
- MAX_STEPS, 16'hFFFF, step limit for the RUN phase and for the PERIOD phase, checked separately; reaching it aborts with timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  initial state offered.
- cfg_ready  out  1  block accepts cfg (high only in IDLE).
- cfg_init  in  N_NODES  initial network state.
- reset_nos  out  1  node load strobe.
- init_state  out  N_NODES  per-node load value (bit i to node i).
- start_s0  out  1  slow-copy step enable.
- start_s1  out  1  fast-copy step enable.
- s0_vec  in  N_NODES  concatenated node s0 outputs.
- s1_vec  in  N_NODES  concatenated node s1 outputs.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_meet_steps  out  CNT_W  s1 steps taken at the meeting point.
- res_period  out  CNT_W  attractor length.
- res_state  out  N_NODES  state at the meeting point (a member of the attractor).
- res_timeout  out  1  aborted at MAX_STEPS.

Behaviour:
- Reset (async, rst_n=0): state returns to IDLE. All counters are 0. reset_nos, start_s0, start_s1, res_valid and res_timeout are 0. res_* data and init_state are 0. A reset mid-run aborts silently and emits no result.
- FSM states: IDLE, LOAD, RUN, PERIOD, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: register cfg_init into init_state, then go to LOAD.
- LOAD (exactly 1 cycle):
  - reset_nos=1; starts are 0.
  - Clear k (step counter) and p (period counter), then go to RUN.
  - Nodes load init_state and arm their internal pass bit, so the first start_s0 moves s0.
- RUN:
  - k counts posedges with start_s1=1. After k steps, s1 holds step k and s0 holds step ceil(k/2).
  - meet = (k != 0) & (k[0] == 0) & (s0_vec == s1_vec).
  - start_s0 = start_s1 = ~meet. This is combinational, so the nodes do not step on the meet cycle.
  - On meet: capture res_state = s0_vec and res_meet_steps = k, then go to PERIOD.
  - Else if k == MAX_STEPS (checked before the step): res_timeout=1, go to DONE.
  - Otherwise k increments.
- PERIOD:
  - start_s0=0, so s0 stays frozen.
  - hit = (p != 0) & (s1_vec == s0_vec).
  - start_s1 = ~hit; p increments on each step.
  - On hit: res_period = p, go to DONE.
  - If p == MAX_STEPS: res_timeout=1, res_period=0, go to DONE.
- DONE:
  - res_valid=1; all res_* fields are held stable.
  - Starts and reset_nos are 0.
  - On res_valid & res_ready: clear res_valid and go to IDLE.
  - Back-to-back is allowed: a new cfg is accepted in the cycle after the handshake.
- Counters do not wrap; MAX_STEPS saturation forces the timeout exit.
- reset_nos and the start strobes are never asserted in the same cycle.
- cfg_valid outside IDLE is ignored; cfg_ready=0.
- Fixed point: the first even-k compare meets, and period = 1.

Decomposition:
- Shared package gnr_ctrl_pkg holds:
  - FSM state enum (3-bit);
  - default CNT_W;
  - the MAX_STEPS constant.
- The top module holds FSM, counters and result registers.
- One natural sub-module: gnr_vec_cmp, a registered-free N_NODES equality comparator reused for the meet and hit checks.
- The network itself is instantiated outside this block.

Test Plan:
- Bench model: 4-node behavioural network whose next state is a ring rotation, init 4'b0001. Required response: res_period=4, res_meet_steps=8, res_state=4'b0001, res_timeout=0.
- Identity network (fixed point), init 4'b1010. Required response: meet at k=2, res_period=1, res_state=4'b1010.
- Network with a 3-step transient into a 2-cycle. Required response: res_period=2, and res_meet_steps equals the even k at which the golden Floyd model meets.
- MAX_STEPS=5 with a 7-cycle attractor. Required response: res_timeout=1, DONE reached after k=5, res_valid stays held while res_ready=0 for 10 cycles.
- Drop rst_n for 1 cycle during PERIOD. Required response: all outputs 0 immediately (async), FSM in IDLE, no res_valid; a subsequent cfg runs cleanly.
- Protocol checks:
  - cfg_valid pulses while in RUN are ignored;
  - reset_nos is asserted for exactly 1 cycle per run;
  - start_s0 is never 1 during PERIOD.
